eth_tx_scheduler: RTL and testbench

Frame-level scheduler for the Ethernet transmit datapath, in the GMII TX clock domain.
- Shares the single TX frame engine between two requesters: ARP frames (from the ARP responder) and UDP frames (from the payload FIFO / UDP source).
- Issues one-cycle start pulses, holds ARP opcode stable, and waits for end-of-frame.
- Enforces the inter-frame gap and recovers from a hung frame via a watchdog.

---
 rtl/eth_tx_scheduler_if.sv | 82 ++++++++
 rtl/eth_tx_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_scheduler_if.sv
//==============================================================================
// Module      : eth_tx_scheduler_if
// Description : Handshake bundle between the Ethernet TX frame scheduler and
//               its requesters (ARP responder, UDP source) and the TX frame
//               datapath.
//                 slave  : scheduler side (drives starts, ack, status)
//                 master : requester / datapath side (drives requests, done)
//               Signals:
//                 arp_req, arp_req_oper      ARP request pulse and opcode
//                 arp_pend                   ARP request latched, not started
//                 udp_req, udp_ack           UDP ready level and grant ack
//                 eth_header_arp_tx_start    one-cycle ARP frame start
//                 eth_header_ip_tx_start     one-cycle UDP/IP frame start
//                 arp_oper                   opcode of current/last ARP frame
//                 tx_frame_done              end-of-frame pulse from datapath
//                 tx_busy, tx_timeout        status / watchdog abort pulse
//               Optional macro ETH_TX_SCHED_STATS_EN adds the frame and
//               timeout counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface eth_tx_scheduler_if;
  logic arp_req;
  logic arp_req_oper;
  logic arp_pend;
  logic udp_req;
  logic udp_ack;
  logic eth_header_arp_tx_start;
  logic eth_header_ip_tx_start;
  logic arp_oper;
  logic tx_frame_done;
  logic tx_busy;
  logic tx_timeout;
`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0] arp_frame_cnt;
  logic [15:0] udp_frame_cnt;
  logic [15:0] timeout_cnt;
`endif

  modport slave (
    input  arp_req,
    input  arp_req_oper,
    input  udp_req,
    input  tx_frame_done,
    output arp_pend,
    output udp_ack,
    output eth_header_arp_tx_start,
    output eth_header_ip_tx_start,
    output arp_oper,
    output tx_busy,
    output tx_timeout
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output arp_frame_cnt,
    output udp_frame_cnt,
    output timeout_cnt
`endif
  );

  modport master (
    output arp_req,
    output arp_req_oper,
    output udp_req,
    output tx_frame_done,
    input  arp_pend,
    input  udp_ack,
    input  eth_header_arp_tx_start,
    input  eth_header_ip_tx_start,
    input  arp_oper,
    input  tx_busy,
    input  tx_timeout
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    input  arp_frame_cnt,
    input  udp_frame_cnt,
    input  timeout_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/eth_tx_scheduler.sv
//==============================================================================
// Module      : eth_tx_scheduler
// Description : Frame-level scheduler for the Ethernet TX datapath (GMII TX
//               clock domain). Arbitrates the single TX frame engine between
//               ARP and UDP requesters with round-robin on ties, issues
//               one-cycle start pulses, holds the ARP opcode stable, waits for
//               end-of-frame, enforces the inter-frame gap and aborts hung
//               frames with a watchdog.
// Ports       : aclk     - GMII TX clock
//               aresetn  - asynchronous active-low reset
//               bus      - eth_tx_scheduler_if.slave (requests, starts, ack,
//                          done, busy, timeout; see interface header)
// Parameters  : IFG_CYCLES     (1..255)    idle cycles after done/abort
//               TIMEOUT_CYCLES (16..65535) watchdog limit in WAIT_DONE
// Options     : `define ETH_TX_SCHED_STATS_EN adds saturating 16-bit
//               arp_frame_cnt, udp_frame_cnt and timeout_cnt outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module eth_tx_scheduler #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  eth_tx_scheduler_if.slave    bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_IFG       = 2'd3;

  localparam logic GRANT_UDP = 1'b0;
  localparam logic GRANT_ARP = 1'b1;

  // Terminal counts; counters stop here instead of wrapping.
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last_grant;
  logic        pend_oper;
  logic [15:0] wd_cnt;
  logic [7:0]  ifg_cnt;

  logic        grant_arp;
  logic        grant_udp;
  logic        timeout_fire;

  // Registered outputs
  logic        arp_pend_q;
  logic        arp_start_q;
  logic        ip_start_q;
  logic        udp_ack_q;
  logic        arp_oper_q;
  logic        tx_busy_q;
  logic        tx_timeout_q;

  //--------------------------------------------------------------------------
  // Next-state and grant decision
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    grant_arp    = 1'b0;
    grant_udp    = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (arp_pend_q && bus.udp_req) begin
          // Tie: serve the type that did not win last time.
          if (last_grant == GRANT_UDP) grant_arp = 1'b1;
          else                         grant_udp = 1'b1;
        end else if (arp_pend_q) begin
          grant_arp = 1'b1;
        end else if (bus.udp_req) begin
          grant_udp = 1'b1;
        end
        if (grant_arp || grant_udp) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done arriving on the expiry cycle takes priority over the abort.
        if (bus.tx_frame_done) begin
          state_nxt = S_IFG;
        end else if (wd_cnt == WD_LAST) begin
          timeout_fire = 1'b1;
          state_nxt    = S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_cnt == IFG_LAST) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State, counters and registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      last_grant   <= GRANT_UDP;
      pend_oper    <= 1'b0;
      wd_cnt       <= 16'd0;
      ifg_cnt      <= 8'd0;
      arp_pend_q   <= 1'b0;
      arp_start_q  <= 1'b0;
      ip_start_q   <= 1'b0;
      udp_ack_q    <= 1'b0;
      arp_oper_q   <= 1'b0;
      tx_busy_q    <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx_busy_q    <= (state_nxt != S_IDLE);
      arp_start_q  <= grant_arp;
      ip_start_q   <= grant_udp;
      udp_ack_q    <= grant_udp;
      tx_timeout_q <= timeout_fire;

      // The opcode presented with the start is the one latched before this
      // edge; a request arriving on the grant edge belongs to the next frame.
      if (grant_arp) begin
        arp_oper_q <= pend_oper;
        last_grant <= GRANT_ARP;
      end else if (grant_udp) begin
        last_grant <= GRANT_UDP;
      end

      // ARP request latch: repeated requests merge, latest opcode wins.
      if (bus.arp_req) begin
        arp_pend_q <= 1'b1;
        pend_oper  <= bus.arp_req_oper;
      end else if (grant_arp) begin
        arp_pend_q <= 1'b0;
      end

      // Watchdog: cleared while in START, counts in WAIT_DONE, holds at limit.
      if (state == S_START) begin
        wd_cnt <= 16'd0;
      end else if ((state == S_WAIT_DONE) && (wd_cnt != WD_LAST)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end

      // Gap counter: armed while waiting so it reads 0 on IFG entry.
      if (state == S_WAIT_DONE) begin
        ifg_cnt <= 8'd0;
      end else if ((state == S_IFG) && (ifg_cnt != IFG_LAST)) begin
        ifg_cnt <= ifg_cnt + 8'd1;
      end
    end
  end

  assign bus.arp_pend                = arp_pend_q;
  assign bus.eth_header_arp_tx_start = arp_start_q;
  assign bus.eth_header_ip_tx_start  = ip_start_q;
  assign bus.udp_ack                 = udp_ack_q;
  assign bus.arp_oper                = arp_oper_q;
  assign bus.tx_busy                 = tx_busy_q;
  assign bus.tx_timeout              = tx_timeout_q;

`ifdef ETH_TX_SCHED_STATS_EN
  //--------------------------------------------------------------------------
  // Saturating frame / abort statistics
  //--------------------------------------------------------------------------
  logic [15:0] arp_frame_cnt_q;
  logic [15:0] udp_frame_cnt_q;
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arp_frame_cnt_q <= 16'd0;
      udp_frame_cnt_q <= 16'd0;
      timeout_cnt_q   <= 16'd0;
    end else begin
      if (grant_arp && (arp_frame_cnt_q != 16'hFFFF))
        arp_frame_cnt_q <= arp_frame_cnt_q + 16'd1;
      if (grant_udp && (udp_frame_cnt_q != 16'hFFFF))
        udp_frame_cnt_q <= udp_frame_cnt_q + 16'd1;
      if (timeout_fire && (timeout_cnt_q != 16'hFFFF))
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign bus.arp_frame_cnt = arp_frame_cnt_q;
  assign bus.udp_frame_cnt = udp_frame_cnt_q;
  assign bus.timeout_cnt   = timeout_cnt_q;
`else
  // Statistics disabled: no counter ports or registers exist.
`endif

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_scheduler.sv
//==============================================================================
// Module      : tb_eth_tx_scheduler
// Description : Directed self-checking bench for eth_tx_scheduler. Main DUT
//               uses IFG_CYCLES=12 / TIMEOUT_CYCLES=4096; a second instance
//               with TIMEOUT_CYCLES=16 exercises the watchdog.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_eth_tx_scheduler;

  localparam int IFG = 12;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  eth_tx_scheduler_if bus ();
  eth_tx_scheduler_if wd_bus ();

  eth_tx_scheduler #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(4096)) u_dut (
    .aclk(clk), .aresetn(aresetn), .bus(bus)
  );

  eth_tx_scheduler #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(16)) u_dut_wd (
    .aclk(clk), .aresetn(aresetn), .bus(wd_bus)
  );

  int checks   = 0;
  int failures = 0;

  // Cycle "n" is the period after a rising edge; inputs set here are seen at
  // the next edge, outputs read here are what that edge produced.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse done in the current cycle D and return in cycle D+IFG+1 (IDLE).
  task automatic complete_frame();
    bus.tx_frame_done = 1'b1;
    tick();
    bus.tx_frame_done = 1'b0;
    repeat (IFG) tick();
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    aresetn = 1'b0;
    repeat (3) tick();
    outs = {bus.arp_pend, bus.udp_ack, bus.eth_header_arp_tx_start,
            bus.eth_header_ip_tx_start, bus.arp_oper, bus.tx_busy, bus.tx_timeout};
    checks++;
    if (outs !== 7'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=0000000", outs); end
    outs = {wd_bus.arp_pend, wd_bus.udp_ack, wd_bus.eth_header_arp_tx_start,
            wd_bus.eth_header_ip_tx_start, wd_bus.arp_oper, wd_bus.tx_busy, wd_bus.tx_timeout};
    checks++;
    if (outs !== 7'b0) begin failures++; $display("FAIL reset_outputs_wd got=%b exp=0000000", outs); end
  endtask

  task automatic test_udp_basic();
    int first_k;
    bus.udp_req = 1'b1;
    @(negedge clk) aresetn = 1'b1;
    tick();  // cycle 1
    checks++;
    if (bus.eth_header_ip_tx_start !== 1'b1) begin failures++; $display("FAIL udp_first_start got=%b exp=1", bus.eth_header_ip_tx_start); end
    checks++;
    if (bus.udp_ack !== 1'b1) begin failures++; $display("FAIL udp_ack_coincident got=%b exp=1", bus.udp_ack); end
    checks++;
    if (bus.tx_busy !== 1'b1 || bus.eth_header_arp_tx_start !== 1'b0) begin
      failures++; $display("FAIL udp_start_busy busy=%b arp_start=%b exp busy=1 arp_start=0", bus.tx_busy, bus.eth_header_arp_tx_start);
    end
    repeat (20) begin
      tick();
      checks++;
      if (bus.eth_header_ip_tx_start !== 1'b0 || bus.udp_ack !== 1'b0) begin
        failures++; $display("FAIL udp_wait_no_start start=%b ack=%b exp 0", bus.eth_header_ip_tx_start, bus.udp_ack);
      end
    end
    bus.tx_frame_done = 1'b1;  // cycle D
    first_k = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      bus.tx_frame_done = 1'b0;
      checks++;
      if (bus.tx_busy !== (k != IFG + 1)) begin
        failures++; $display("FAIL udp_busy_gap k=%0d got=%b exp=%b", k, bus.tx_busy, (k != IFG + 1));
      end
      if (bus.eth_header_ip_tx_start === 1'b1) begin
        first_k = k;
        checks++;
        if (bus.udp_ack !== 1'b1) begin failures++; $display("FAIL udp_ack_second got=%b exp=1", bus.udp_ack); end
        break;
      end
    end
    checks++;
    if (first_k != IFG + 2) begin failures++; $display("FAIL udp_restart_latency got=%0d exp=%0d", first_k, IFG + 2); end
    bus.udp_req = 1'b0;
    tick();
    complete_frame();
  endtask

  task automatic test_arp_single();
    bus.arp_req = 1'b1;
    bus.arp_req_oper = 1'b1;
    tick();
    bus.arp_req = 1'b0;
    bus.arp_req_oper = 1'b0;
    checks++;
    if (bus.arp_pend !== 1'b1 || bus.eth_header_arp_tx_start !== 1'b0 || bus.tx_busy !== 1'b0) begin
      failures++; $display("FAIL arp_pend_latency pend=%b start=%b busy=%b exp 1 0 0", bus.arp_pend, bus.eth_header_arp_tx_start, bus.tx_busy);
    end
    tick();
    checks++;
    if (bus.eth_header_arp_tx_start !== 1'b1 || bus.eth_header_ip_tx_start !== 1'b0) begin
      failures++; $display("FAIL arp_start_latency arp=%b ip=%b exp 1 0", bus.eth_header_arp_tx_start, bus.eth_header_ip_tx_start);
    end
    checks++;
    if (bus.arp_oper !== 1'b1 || bus.arp_pend !== 1'b0) begin
      failures++; $display("FAIL arp_oper_capture oper=%b pend=%b exp 1 0", bus.arp_oper, bus.arp_pend);
    end
    bus.udp_req = 1'b1;
    tick();
    checks++;
    if (bus.eth_header_arp_tx_start !== 1'b0) begin failures++; $display("FAIL arp_start_one_cycle got=%b exp=0", bus.eth_header_arp_tx_start); end
    complete_frame();
    tick();
    checks++;
    if (bus.eth_header_ip_tx_start !== 1'b1 || bus.arp_oper !== 1'b1) begin
      failures++; $display("FAIL arp_oper_hold ip_start=%b oper=%b exp 1 1", bus.eth_header_ip_tx_start, bus.arp_oper);
    end
    bus.udp_req = 1'b0;
    tick();
    complete_frame();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_arp;
    logic       got_arp;
    int         gap;
    exp_arp = 4'b0101;  // frame f is ARP when bit f set: ARP, UDP, ARP, UDP
    aresetn = 1'b0;
    tick();
    @(negedge clk) aresetn = 1'b1;
    tick();
    bus.arp_req = 1'b1;
    bus.arp_req_oper = 1'b0;
    tick();
    bus.arp_req = 1'b0;
    bus.udp_req = 1'b1;
    for (int f = 0; f < 4; f++) begin
      gap = -1;
      got_arp = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        bus.tx_frame_done = 1'b0;
        if (bus.eth_header_arp_tx_start === 1'b1 || bus.eth_header_ip_tx_start === 1'b1) begin
          gap = k;
          got_arp = bus.eth_header_arp_tx_start;
          break;
        end
      end
      checks++;
      if (gap < 0 || got_arp !== exp_arp[f]) begin
        failures++; $display("FAIL rr_order frame=%0d got_arp=%b exp_arp=%b gap=%0d", f, got_arp, exp_arp[f], gap);
      end
      if (f > 0) begin
        checks++;
        if (gap != IFG + 2) begin failures++; $display("FAIL rr_gap frame=%0d got=%0d exp=%0d", f, gap, IFG + 2); end
      end
      if (f == 2) begin
        checks++;
        if (bus.arp_oper !== 1'b1) begin failures++; $display("FAIL rr_arp_oper got=%b exp=1", bus.arp_oper); end
      end
      if (f == 3) bus.udp_req = 1'b0;
      tick();
      if (f == 0) begin
        bus.arp_req = 1'b1;
        bus.arp_req_oper = 1'b1;
      end
      tick();
      bus.arp_req = 1'b0;
      bus.arp_req_oper = 1'b0;
      repeat (3) tick();
      bus.tx_frame_done = 1'b1;
    end
    tick();
    bus.tx_frame_done = 1'b0;
    repeat (IFG + 4) tick();
    checks++;
    if (bus.arp_pend !== 1'b0 || bus.tx_busy !== 1'b0) begin
      failures++; $display("FAIL rr_drained pend=%b busy=%b exp 0 0", bus.arp_pend, bus.tx_busy);
    end
  endtask

  task automatic test_arp_merge();
    int arp_starts;
    int first_k;
    logic oper_at_start;
    bool_ip: begin end
    bus.udp_req = 1'b1;
    tick();
    bus.udp_req = 1'b0;
    tick();
    bus.arp_req = 1'b1; bus.arp_req_oper = 1'b0;
    tick();
    bus.arp_req = 1'b0;
    tick();
    bus.arp_req = 1'b1; bus.arp_req_oper = 1'b1;
    tick();
    bus.arp_req = 1'b0; bus.arp_req_oper = 1'b0;
    checks++;
    if (bus.arp_pend !== 1'b1 || bus.tx_busy !== 1'b1) begin
      failures++; $display("FAIL merge_pending pend=%b busy=%b exp 1 1", bus.arp_pend, bus.tx_busy);
    end
    repeat (2) tick();
    bus.tx_frame_done = 1'b1;
    arp_starts = 0;
    first_k = -1;
    oper_at_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bus.tx_frame_done = 1'b0;
      if (bus.eth_header_arp_tx_start === 1'b1) begin
        arp_starts++;
        if (first_k < 0) begin first_k = k; oper_at_start = bus.arp_oper; end
      end
      checks++;
      if (bus.eth_header_ip_tx_start !== 1'b0) begin failures++; $display("FAIL merge_no_udp k=%0d got=1 exp=0", k); end
    end
    checks++;
    if (arp_starts != 1) begin failures++; $display("FAIL merge_one_frame got=%0d exp=1", arp_starts); end
    checks++;
    if (first_k != IFG + 2 || oper_at_start !== 1'b1) begin
      failures++; $display("FAIL merge_latest_oper k=%0d oper=%b exp k=%0d oper=1", first_k, oper_at_start, IFG + 2);
    end
    complete_frame();
  endtask

  task automatic test_udp_cancel();
    bus.udp_req = 1'b1;
    tick();
    bus.udp_req = 1'b0;
    tick();
    bus.tx_frame_done = 1'b1;
    tick();
    bus.tx_frame_done = 1'b0;
    bus.udp_req = 1'b1;   // raised during IFG ...
    repeat (5) tick();
    bus.udp_req = 1'b0;   // ... and withdrawn before IFG ends
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.eth_header_ip_tx_start !== 1'b0 || bus.udp_ack !== 1'b0) begin
        failures++; $display("FAIL cancel_no_ack k=%0d start=%b ack=%b exp 0 0", k, bus.eth_header_ip_tx_start, bus.udp_ack);
      end
    end
    checks++;
    if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL cancel_idle got=%b exp=0", bus.tx_busy); end
  endtask

  task automatic test_timeout();
    int tk;
    int pulses;
    wd_bus.udp_req = 1'b1;
    tick();  // cycle S
    wd_bus.udp_req = 1'b0;
    checks++;
    if (wd_bus.eth_header_ip_tx_start !== 1'b1) begin failures++; $display("FAIL wd_start got=%b exp=1", wd_bus.eth_header_ip_tx_start); end
    tk = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (wd_bus.tx_timeout === 1'b1) begin tk = k; break; end
    end
    checks++;
    if (tk != 17) begin failures++; $display("FAIL wd_timeout_latency got=%0d exp=17", tk); end
    tick();
    checks++;
    if (wd_bus.tx_timeout !== 1'b0 || wd_bus.tx_busy !== 1'b1) begin
      failures++; $display("FAIL wd_pulse_width timeout=%b busy=%b exp 0 1", wd_bus.tx_timeout, wd_bus.tx_busy);
    end
    repeat (IFG - 2) tick();  // cycle T+IFG-1, still in IFG
    checks++;
    if (wd_bus.tx_busy !== 1'b1) begin failures++; $display("FAIL wd_ifg_busy got=%b exp=1", wd_bus.tx_busy); end
    tick();                   // cycle T+IFG, IDLE
    checks++;
    if (wd_bus.tx_busy !== 1'b0) begin failures++; $display("FAIL wd_back_idle got=%b exp=0", wd_bus.tx_busy); end
    wd_bus.tx_frame_done = 1'b1;  // stray done in IDLE
    tick();
    wd_bus.tx_frame_done = 1'b0;
    tick();
    checks++;
    if (wd_bus.tx_busy !== 1'b0 || wd_bus.tx_timeout !== 1'b0) begin
      failures++; $display("FAIL wd_stray_done busy=%b timeout=%b exp 0 0", wd_bus.tx_busy, wd_bus.tx_timeout);
    end
`ifdef ETH_TX_SCHED_STATS_EN
    checks++;
    if (wd_bus.timeout_cnt !== 16'd1) begin failures++; $display("FAIL wd_timeout_cnt got=%0d exp=1", wd_bus.timeout_cnt); end
`endif
    // Done on the expiry cycle (watchdog at limit) must win.
    wd_bus.udp_req = 1'b1;
    tick();  // cycle S
    wd_bus.udp_req = 1'b0;
    repeat (16) tick();  // cycle S+16
    wd_bus.tx_frame_done = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      wd_bus.tx_frame_done = 1'b0;
      if (wd_bus.tx_timeout === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL wd_done_wins got=%0d exp=0", pulses); end
    repeat (IFG) tick();
  endtask

  task automatic test_async_reset();
    logic [6:0] outs;
    bus.udp_req = 1'b1;
    tick();
    bus.udp_req = 1'b0;
    tick();
    bus.arp_req = 1'b1; bus.arp_req_oper = 1'b1;
    tick();
    bus.arp_req = 1'b0; bus.arp_req_oper = 1'b0;
    checks++;
    if (bus.arp_pend !== 1'b1 || bus.tx_busy !== 1'b1) begin
      failures++; $display("FAIL ar_precondition pend=%b busy=%b exp 1 1", bus.arp_pend, bus.tx_busy);
    end
    #2 aresetn = 1'b0;
    #1;
    outs = {bus.arp_pend, bus.udp_ack, bus.eth_header_arp_tx_start,
            bus.eth_header_ip_tx_start, bus.arp_oper, bus.tx_busy, bus.tx_timeout};
    checks++;
    if (outs !== 7'b0) begin failures++; $display("FAIL ar_outputs_cleared got=%b exp=0000000", outs); end
`ifdef ETH_TX_SCHED_STATS_EN
    checks++;
    if ({bus.arp_frame_cnt, bus.udp_frame_cnt, bus.timeout_cnt} !== 48'd0) begin
      failures++; $display("FAIL ar_stats_cleared arp=%0d udp=%0d to=%0d exp 0", bus.arp_frame_cnt, bus.udp_frame_cnt, bus.timeout_cnt);
    end
`endif
    @(negedge clk) aresetn = 1'b1;
    tick();
    bus.tx_frame_done = 1'b1;
    tick();
    bus.tx_frame_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.tx_busy !== 1'b0 || bus.eth_header_arp_tx_start !== 1'b0) begin
        failures++; $display("FAIL ar_dropped k=%0d busy=%b arp_start=%b exp 0 0", k, bus.tx_busy, bus.eth_header_arp_tx_start);
      end
    end
  endtask

  initial begin
    bus.arp_req = 1'b0;  bus.arp_req_oper = 1'b0;  bus.udp_req = 1'b0;  bus.tx_frame_done = 1'b0;
    wd_bus.arp_req = 1'b0; wd_bus.arp_req_oper = 1'b0; wd_bus.udp_req = 1'b0; wd_bus.tx_frame_done = 1'b0;
    test_reset();
    test_udp_basic();
    test_arp_single();
    test_round_robin();
    test_arp_merge();
    test_udp_cancel();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
